// File: rtl/booth_seq_mult_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//   state_t    : controller states (ST_IDLE, ST_RUN)
//   booth_op_t : operation selected by the low two bits of the Q register
package booth_seq_mult_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // {Q[0], Q-1} pairs: 00 and 11 only shift, 01 adds M, 10 subtracts M.
    typedef enum logic [1:0] {
        BOOTH_NOP   = 2'b00,
        BOOTH_ADD   = 2'b01,
        BOOTH_SUB   = 2'b10,
        BOOTH_NOP_H = 2'b11
    } booth_op_t;

endpackage

// File: rtl/booth_seq_mult_step.sv
// One combinational radix-2 Booth iteration.
//   a      : accumulator (AW bits)
//   m      : sign-extended multiplicand (AW bits)
//   q      : {multiplier remainder, Q-1} (AW bits)
//   a_next : accumulator after add/sub and arithmetic shift
//   q_next : Q after shift (LSB of the sum enters its MSB)
module booth_step
    import booth_seq_mult_pkg::*;
#(
    parameter int unsigned AW = 9
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] m,
    input  logic [AW-1:0] q,
    output logic [AW-1:0] a_next,
    output logic [AW-1:0] q_next
);

    logic [AW-1:0] sum;
    booth_op_t     op;

    always_comb begin
        op  = booth_op_t'(q[1:0]);
        sum = a;
        case (op)
            BOOTH_ADD: sum = a + m;
            BOOTH_SUB: sum = a - m;
            default:   sum = a;
        endcase
        // Arithmetic shift of the combined {sum, q} register.
        a_next = {sum[AW-1], sum[AW-1:1]};
        q_next = {sum[0], q[AW-1:1]};
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth signed multiplier (WIDTH iterations per multiply).
//   clk, rst : rising-edge clock, synchronous active-high reset
//   start    : request, sampled only while idle
//   mcand    : signed multiplicand, captured on the accepting edge
//   mplier   : signed multiplier, captured on the accepting edge
//   busy     : operation in progress
//   done     : one-cycle completion pulse
//   product  : signed 2*WIDTH product, held until the next completion
module booth_seq_mult
    import booth_seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned AW    = WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    a_q, m_q, q_q;
    logic [AW-1:0]    a_nx, q_nx;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             last_step;

    booth_step #(.AW(AW)) u_step (
        .a      (a_q),
        .m      (m_q),
        .q      (q_q),
        .a_next (a_nx),
        .q_next (q_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    last_step = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            done <= last_step;
            if (accept) begin
                a_q   <= '0;
                m_q   <= {mcand[WIDTH-1], mcand};
                q_q   <= {mplier, 1'b0};
                cnt_q <= CNT_W'(WIDTH);
                busy  <= 1'b1;
            end else if (state_q == ST_RUN) begin
                a_q   <= a_nx;
                q_q   <= q_nx;
                cnt_q <= cnt_q - CNT_W'(1);
                if (last_step) begin
                    busy <= 1'b0;
                    // Top bit of the WIDTH+1 accumulator is only a sign guard.
                    product <= {a_nx[WIDTH-1:0], q_nx[WIDTH:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
module tb_booth_seq_mult;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] mcand, mplier;
    logic             busy, done;
    logic [2*WIDTH-1:0] product;

    always #5 clk = ~clk;

    booth_seq_mult #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a multiply takes WIDTH cycles after acceptance,
    // then the product appears together with a one-cycle done.
    int          m_left = 0;
    logic [15:0] m_pend = '0;
    logic [15:0] m_prod = '0;
    bit          m_done = 1'b0;

    always @(posedge clk) begin
        int a, b;
        if (rst) begin
            m_left = 0;
            m_prod = '0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_prod = m_pend;
                    m_done = 1'b1;
                end
            end else if (start) begin
                a = $signed(mcand);
                b = $signed(mplier);
                m_pend = 16'(a * b);
                m_left = WIDTH;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_left > 0));
            check("done", 32'(done), 32'(m_done));
            check("product", 32'(product), 32'(m_prod));
        end
    end

    // Issue one multiply and wait (bounded) for its done pulse.
    task automatic do_op(input logic [7:0] mc, input logic [7:0] mp,
                         input logic [15:0] exp, input string name,
                         input int exp_busy);
        int  busy_cycles;
        bit  got;
        busy_cycles = 0;
        got = 1'b0;
        start  = 1'b1;
        mcand  = mc;
        mplier = mp;
        @(negedge clk);
        start  = 1'b0;
        mcand  = 8'($urandom);
        mplier = 8'($urandom);
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
        check(name, 32'(product), 32'(exp));
        if (exp_busy > 0) check({name, "_busy_len"}, 32'(busy_cycles), 32'(exp_busy));
    endtask

    initial begin
        int a, b, gap;
        bit seen;
        rst = 1'b1;
        start = 1'b0;
        mcand = '0;
        mplier = '0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_product", 32'(product), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        do_op(8'd3,   8'd4,   16'h000C, "3x4",       8);
        do_op(8'hFD,  8'd4,   16'hFFF4, "m3x4",      8);
        do_op(8'h80,  8'h80,  16'h4000, "m128xm128", 8);
        do_op(8'd127, 8'h80,  16'hC080, "127xm128",  8);

        // Back-to-back with start held high.
        start = 1'b1; mcand = 8'd3; mplier = 8'd4;
        @(negedge clk);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                mcand = 8'($urandom); mplier = 8'($urandom);
                @(negedge clk);
            end
        end
        check("b2b_first_done", 32'(seen), 32'd1);
        check("b2b_first", 32'(product), 32'h000C);
        mcand = 8'd10; mplier = 8'hFB;
        @(negedge clk);
        gap = 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                mcand = 8'($urandom); mplier = 8'($urandom);
                @(negedge clk);
                gap++;
            end
        end
        start = 1'b0;
        check("b2b_second_done", 32'(seen), 32'd1);
        check("b2b_gap", 32'(gap), 32'd9);
        check("b2b_second", 32'(product), 32'hFFCE);
        @(negedge clk);

        // Reset in the middle of a run.
        start = 1'b1; mcand = 8'd100; mplier = 8'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'h0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done) seen = 1'b1;
            @(negedge clk);
        end
        check("rst_no_done", 32'(seen), 32'd0);
        do_op(8'd5, 8'hF9, 16'hFFDD, "5xm7", 8);

        // Random operand pairs against a plain multiply.
        for (int k = 0; k < 1000; k++) begin
            logic [7:0] x, y;
            x = 8'($urandom);
            y = 8'($urandom);
            a = $signed(x);
            b = $signed(y);
            do_op(x, y, 16'(a * b), "rand", 0);
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
